// File: rtl/id_stage.sv
// Instruction-decode stage: class-ISA decode into a registered bundle, with
// register scoreboard interlock, 2-bit branch predictor, flush and halt.
module id_stage #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned BHT_ENTRIES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_first_ld,
    output logic              out_special,
    output logic [3:0]        out_second_ld,
    output logic [2:0]        out_alu_oc,
    output logic [3:0]        out_cond,
    output logic [2:0]        out_dest,
    output logic [2:0]        out_op1,
    output logic [2:0]        out_op2,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_branch,
    output logic              out_illegal,
    output logic              out_pred_taken,
    output logic [31:0]       out_pc,
    output logic              halted,
    input  logic              wb_valid,
    input  logic [2:0]        wb_addr,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic              upd_taken,
    input  logic              flush
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
    localparam int unsigned NREG  = 8;

    logic [1:0]        bht [BHT_ENTRIES];
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pend_eff;
    logic [NREG-1:0]   pend_next;
    logic [IDX_W-1:0]  lk_idx;
    logic [IDX_W-1:0]  up_idx;

    logic [4:0]        key;
    logic              alu10;
    logic [2:0]        d_dest, d_op1, d_op2;
    logic              d_use1, d_use2;
    logic              d_rw, d_mr, d_mw, d_br, d_ill, d_pred, d_halt;
    logic [3:0]        d_cond;
    logic [DATA_W-1:0] d_imm;
    logic [DATA_W-1:0] imm_z, imm_s;
    logic              hazard;
    logic              accept;

    logic unused_upd_pc;
    assign unused_upd_pc = ^{upd_pc[31:IDX_W+2], upd_pc[1:0]};

    assign lk_idx = in_pc[IDX_W+1:2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign key    = in_instr[29:25];
    assign imm_z  = DATA_W'(in_instr[15:0]);
    assign imm_s  = DATA_W'($signed(in_instr[15:0]));

    // The ten flag/no-flag ALU codes shared by classes 00 and 01
    always_comb begin
        alu10 = 1'b0;
        case (key)
            5'b10001, 5'b10010, 5'b10011, 5'b10100, 5'b10101,
            5'b11001, 5'b11010, 5'b11011, 5'b11100, 5'b11101: alu10 = 1'b1;
            default: alu10 = 1'b0;
        endcase
    end

    // Combinational decode of the instruction currently offered by fetch
    always_comb begin
        d_dest = '0; d_op1 = '0; d_op2 = '0;
        d_use1 = 1'b0; d_use2 = 1'b0;
        d_rw = 1'b0; d_mr = 1'b0; d_mw = 1'b0; d_br = 1'b0;
        d_ill = 1'b0; d_pred = 1'b0; d_halt = 1'b0;
        d_cond = '0; d_imm = '0;
        case (in_instr[31:30])
            2'b00: begin
                d_imm = imm_z;
                if (key == 5'b00000 || key == 5'b00001) begin
                    d_rw = 1'b1;
                end else if (alu10 || key == 5'b00100 || key == 5'b00101 ||
                             key == 5'b00010 || key == 5'b00011) begin
                    d_rw = 1'b1; d_use1 = 1'b1;
                end else begin
                    d_ill = 1'b1;
                end
            end
            2'b01: begin
                if (alu10) begin
                    d_rw = 1'b1; d_use1 = 1'b1; d_use2 = 1'b1;
                end else if (key == 5'b10110) begin
                    d_rw = 1'b1; d_use1 = 1'b1;
                end else begin
                    d_ill = 1'b1;
                end
            end
            2'b10: begin
                d_imm = imm_s;
                if (in_instr[25]) begin
                    d_mw = 1'b1; d_use1 = 1'b1; d_use2 = 1'b1;
                    d_op1 = in_instr[24:22];
                    d_op2 = in_instr[21:19];
                end else begin
                    d_mr = 1'b1; d_rw = 1'b1; d_use1 = 1'b1;
                end
            end
            default: begin
                case (in_instr[28:25])
                    4'b0000: begin
                        d_br = 1'b1; d_pred = 1'b1; d_imm = imm_s;
                    end
                    4'b0001: begin
                        d_br = 1'b1; d_pred = bht[lk_idx][1]; d_imm = imm_s;
                        d_cond = in_instr[24:21];
                    end
                    4'b0010: begin
                        d_br = 1'b1; d_pred = 1'b1; d_imm = imm_s; d_use1 = 1'b1;
                    end
                    default: d_halt = !in_instr[27] && in_instr[28];
                endcase
            end
        endcase
        if (!d_mw) begin
            if (d_rw)   d_dest = in_instr[24:22];
            if (d_use1) d_op1  = in_instr[21:19];
            if (d_use2) d_op2  = in_instr[18:16];
        end
    end

    // Scoreboard: a write-back this cycle releases its register immediately
    always_comb begin
        pend_eff = pending;
        if (wb_valid) pend_eff[wb_addr] = 1'b0;
        hazard = (d_use1 && pend_eff[d_op1]) ||
                 (d_use2 && pend_eff[d_op2]) ||
                 (d_rw   && pend_eff[d_dest]);
        in_ready = !rst && !halted && !flush && !hazard && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
        pend_next = pend_eff;
        if (flush && out_valid && out_reg_write) pend_next[out_dest] = 1'b0;
        if (accept && d_rw) pend_next[d_dest] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= pend_next;
    end

    // Saturating 2-bit direction counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) bht[i] <= 2'b01;
        end else if (upd_valid) begin
            if (upd_taken && bht[up_idx] != 2'b11)
                bht[up_idx] <= bht[up_idx] + 2'd1;
            else if (!upd_taken && bht[up_idx] != 2'b00)
                bht[up_idx] <= bht[up_idx] - 2'd1;
        end
    end

    // Output bundle register; flush beats accept, held while stalled downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_first_ld   <= '0;
            out_special    <= 1'b0;
            out_second_ld  <= '0;
            out_alu_oc     <= '0;
            out_cond       <= '0;
            out_dest       <= '0;
            out_op1        <= '0;
            out_op2        <= '0;
            out_imm        <= '0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_branch     <= 1'b0;
            out_illegal    <= 1'b0;
            out_pred_taken <= 1'b0;
            out_pc         <= '0;
            halted         <= 1'b0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid      <= 1'b1;
                out_first_ld   <= in_instr[31:30];
                out_special    <= in_instr[29];
                out_second_ld  <= in_instr[28:25];
                out_alu_oc     <= in_instr[27:25];
                out_cond       <= d_cond;
                out_dest       <= d_dest;
                out_op1        <= d_op1;
                out_op2        <= d_op2;
                out_imm        <= d_imm;
                out_reg_write  <= d_rw;
                out_mem_read   <= d_mr;
                out_mem_write  <= d_mw;
                out_branch     <= d_br;
                out_illegal    <= d_ill;
                out_pred_taken <= d_pred;
                out_pc         <= in_pc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && d_halt) halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural decode/scoreboard/predictor model.
module tb_id_stage;

    typedef struct packed {
        logic [1:0]  first;
        logic        special;
        logic [3:0]  second;
        logic [2:0]  alu;
        logic [3:0]  cond;
        logic [2:0]  dest;
        logic [2:0]  op1;
        logic [2:0]  op2;
        logic [31:0] imm;
        logic        rw, mr, mw, br, ill, pred;
        logic [31:0] pc;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_instr, in_pc;
    logic        out_valid, out_ready;
    logic [1:0]  out_first_ld;
    logic        out_special;
    logic [3:0]  out_second_ld;
    logic [2:0]  out_alu_oc;
    logic [3:0]  out_cond;
    logic [2:0]  out_dest, out_op1, out_op2;
    logic [31:0] out_imm;
    logic        out_reg_write, out_mem_read, out_mem_write, out_branch, out_illegal;
    logic        out_pred_taken;
    logic [31:0] out_pc;
    logic        halted;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        flush;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit [7:0] m_pending;
    int       m_ctr [16];
    bit       m_halted;
    bit       m_valid;
    bundle_t  m_out;

    always #5 clk = ~clk;

    id_stage #(.DATA_W(32), .BHT_ENTRIES(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_first_ld(out_first_ld), .out_special(out_special),
        .out_second_ld(out_second_ld), .out_alu_oc(out_alu_oc), .out_cond(out_cond),
        .out_dest(out_dest), .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_branch(out_branch), .out_illegal(out_illegal),
        .out_pred_taken(out_pred_taken), .out_pc(out_pc), .halted(halted),
        .wb_valid(wb_valid), .wb_addr(wb_addr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .flush(flush)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bundle_t dut_bundle();
        bundle_t b;
        b.first = out_first_ld;  b.special = out_special; b.second = out_second_ld;
        b.alu   = out_alu_oc;    b.cond = out_cond;       b.dest = out_dest;
        b.op1   = out_op1;       b.op2 = out_op2;         b.imm = out_imm;
        b.rw    = out_reg_write; b.mr = out_mem_read;     b.mw = out_mem_write;
        b.br    = out_branch;    b.ill = out_illegal;     b.pred = out_pred_taken;
        b.pc    = out_pc;
        return b;
    endfunction

    // Decode straight from the ISA description
    function automatic bundle_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                             output bit u1, output bit u2, output bit hlt);
        bundle_t b;
        int k;
        logic [31:0] sx, zx;
        bit alu_code;
        b = '0;
        u1 = 0; u2 = 0; hlt = 0;
        b.first = ins[31:30]; b.special = ins[29]; b.second = ins[28:25];
        b.alu = ins[27:25]; b.pc = pc;
        k  = int'(ins[29:25]);
        zx = 32'(ins[15:0]);
        sx = ins[15] ? (zx | 32'hFFFF_0000) : zx;
        alu_code = (k >= 17 && k <= 21) || (k >= 25 && k <= 29);
        case (int'(ins[31:30]))
            0: begin
                b.imm = zx;
                if (k <= 1) b.rw = 1;
                else if (alu_code || (k >= 2 && k <= 5)) begin b.rw = 1; u1 = 1; end
                else b.ill = 1;
            end
            1: begin
                if (alu_code) begin b.rw = 1; u1 = 1; u2 = 1; end
                else if (k == 22) begin b.rw = 1; u1 = 1; end
                else b.ill = 1;
            end
            2: begin
                b.imm = sx;
                if (ins[25]) begin
                    b.mw = 1; u1 = 1; u2 = 1;
                    b.op1 = ins[24:22]; b.op2 = ins[21:19];
                end else begin
                    b.mr = 1; b.rw = 1; u1 = 1;
                end
            end
            default: begin
                if (int'(ins[28:25]) <= 2) begin
                    b.br = 1; b.imm = sx;
                    b.pred = (ins[28:25] == 4'd1) ? (m_ctr[pc[5:2]] >= 2) : 1'b1;
                    if (ins[28:25] == 4'd1) b.cond = ins[24:21];
                    if (ins[28:25] == 4'd2) u1 = 1;
                end else begin
                    hlt = !ins[27] && ins[28];
                end
            end
        endcase
        if (!b.mw) begin
            if (b.rw) b.dest = ins[24:22];
            if (u1)   b.op1  = ins[21:19];
            if (u2)   b.op2  = ins[18:16];
        end
        return b;
    endfunction

    task automatic model_reset();
        m_pending = '0;
        for (int i = 0; i < 16; i++) m_ctr[i] = 1;
        m_halted = 0;
        m_valid = 0;
        m_out = '0;
    endtask

    // One clock: drive inputs at negedge, check in_ready, advance model, check outputs
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit ordy, input bit wbv, input logic [2:0] wba,
                        input bit uv, input logic [31:0] upc, input bit ut, input bit fl);
        bundle_t d;
        bit u1, u2, hlt, haz, er, acc;
        bit [7:0] pe;
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy;
        wb_valid = wbv; wb_addr = wba; upd_valid = uv; upd_pc = upc; upd_taken = ut;
        flush = fl;
        #1;
        d = model_decode(ins, pc, u1, u2, hlt);
        pe = m_pending;
        if (wbv) pe[wba] = 0;
        haz = (u1 && pe[d.op1]) || (u2 && pe[d.op2]) || (d.rw && pe[d.dest]);
        er  = !m_halted && !fl && !haz && (!m_valid || ordy);
        chk("in_ready", 128'(in_ready), 128'(er));
        acc = v && er;
        @(posedge clk);
        if (wbv) m_pending[wba] = 0;
        if (fl && m_valid && m_out.rw) m_pending[m_out.dest] = 0;
        if (acc && d.rw) m_pending[d.dest] = 1;
        if (uv) begin
            if (ut) m_ctr[upc[5:2]] = (m_ctr[upc[5:2]] < 3) ? m_ctr[upc[5:2]] + 1 : 3;
            else    m_ctr[upc[5:2]] = (m_ctr[upc[5:2]] > 0) ? m_ctr[upc[5:2]] - 1 : 0;
        end
        if (fl) m_valid = 0;
        else if (acc) begin m_out = d; m_valid = 1; end
        else if (ordy) m_valid = 0;
        if (acc && hlt) m_halted = 1;
        @(negedge clk);
        chk("out_valid", 128'(out_valid), 128'(m_valid));
        chk("halted", 128'(halted), 128'(m_halted));
        if (m_valid) chk("bundle", 128'(dut_bundle()), 128'(m_out));
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        step(1, ins, pc, 1, 0, 3'd0, 0, 32'd0, 0, 0);
    endtask

    task automatic idle_wb(input logic [2:0] a);
        step(0, 32'd0, 32'd0, 1, 1, a, 0, 32'd0, 0, 0);
    endtask

    task automatic train(input logic [31:0] pc, input bit t);
        step(0, 32'd0, 32'd0, 1, 0, 3'd0, 1, pc, t, 0);
    endtask

    initial begin
        logic [31:0] ins;
        rst = 1; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
        wb_valid = 0; wb_addr = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0; flush = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_halted", 128'(halted), 128'(0));
        chk("rst_bundle", 128'(dut_bundle()), 128'(0));
        rst = 0;

        // Weakly-not-taken after reset
        issue(32'hC260_0000, 32'h0);
        chk("bcond_pc0_pred", 128'(out_pred_taken), 128'(0));

        // RAW interlock released by same-cycle write-back
        issue(32'h0080_1234, 32'h4);
        chk("mov_imm", 128'(out_imm), 128'(32'h1234));
        repeat (3) step(1, 32'h22D0_0001, 32'h8, 1, 0, 3'd0, 0, 32'd0, 0, 0);
        step(1, 32'h22D0_0001, 32'h8, 1, 1, 3'd2, 0, 32'd0, 0, 0);
        chk("add_dest", 128'(out_dest), 128'(3));
        idle_wb(3'd3);

        issue(32'h8060_FFFC, 32'hC);
        chk("ld_imm", 128'(out_imm), 128'(32'hFFFF_FFFC));
        chk("ld_flags", 128'({out_mem_read, out_dest, out_op1}), 128'({1'b1, 3'd1, 3'd4}));
        idle_wb(3'd1);
        issue(32'h0000_8000, 32'h10);
        chk("mov_imm_zx", 128'(out_imm), 128'(32'h0000_8000));
        idle_wb(3'd0);

        // Predictor training and saturation at zero
        train(32'h40, 1); train(32'h40, 1);
        issue(32'hC200_0000, 32'h40);
        chk("bcond_trained", 128'(out_pred_taken), 128'(1));
        repeat (5) train(32'h40, 0);
        train(32'h40, 1);
        issue(32'hC200_0000, 32'h40);
        chk("bcond_saturated", 128'(out_pred_taken), 128'(0));
        train(32'h40, 1);

        // Held bundle, then flush frees its destination
        issue(32'h0140_0005, 32'h20);
        repeat (3) begin
            step(0, 32'd0, 32'd0, 0, 0, 3'd0, 0, 32'd0, 0, 0);
            chk("held_dest", 128'(out_dest), 128'(5));
        end
        step(0, 32'd0, 32'd0, 0, 0, 3'd0, 0, 32'd0, 0, 1);
        chk("flush_valid", 128'(out_valid), 128'(0));
        issue(32'h23A8_0000, 32'h24);
        chk("reader_after_flush", 128'({out_valid, out_op1}), 128'({1'b1, 3'd5}));
        idle_wb(3'd6);

        // Leave r7 pending, then halt
        issue(32'h01C0_0000, 32'h28);
        issue(32'hD000_0000, 32'h2C);
        chk("halt_presented", 128'({out_valid, halted}), 128'({1'b1, 1'b1}));
        issue(32'h0080_0000, 32'h30);
        issue(32'h0080_0000, 32'h34);
        chk("halt_sticky", 128'({in_ready, halted}), 128'({1'b0, 1'b1}));

        // Asynchronous reset in the middle of a stall
        in_valid = 1; in_instr = 32'h0080_0000;
        #2 rst = 1;
        #1;
        chk("async_rst_ready", 128'(in_ready), 128'(0));
        chk("async_rst_valid", 128'(out_valid), 128'(0));
        chk("async_rst_halted", 128'(halted), 128'(0));
        @(negedge clk);
        rst = 0;
        model_reset();
        issue(32'hC200_0000, 32'h40);
        chk("ctr_after_rst", 128'(out_pred_taken), 128'(0));
        issue(32'h2278_0000, 32'h44);
        chk("pending_after_rst", 128'(out_valid), 128'(1));
        idle_wb(3'd1);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            ins = $urandom;
            if (ins[31:30] == 2'b11 && ins[28:25] > 4'd2 && !ins[27] && ins[28]) ins[27] = 1'b1;
            step(($urandom % 4) != 0, ins, 32'($urandom_range(0, 63)) << 2,
                 ($urandom % 4) != 0, ($urandom % 3) == 0, 3'($urandom),
                 ($urandom % 3) == 0, 32'($urandom_range(0, 63)) << 2, 1'($urandom),
                 ($urandom % 20) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
